// File: rtl/mpnn_mac_sequencer.sv
// Sequencer for the 4-lane 17-bit mixed-precision multiplier: unpacks packed
// weight/activation words, issues them over 1-4 passes and accumulates lane products.
module mpnn_mac_sequencer #(
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      weights_i,
    input  logic [31:0]      acts_i,
    input  logic [1:0]       prec_i,
    input  logic             act_signed_i,
    input  logic             acc_clr_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [ACC_W-1:0] res_o,
    output logic             busy_o,
    output logic [67:0]      mult_weights_o,
    output logic [67:0]      mult_acts_o,
    output logic             mult_normal_o,
    input  logic [135:0]     mult_prods_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic [31:0]        r_w;
    logic [31:0]        r_a;
    logic [1:0]         r_prec;
    logic               r_asg;
    logic [1:0]         r_pass;
    logic [135:0]       r_prod;
    logic [ACC_W-1:0]   r_acc;

    logic [1:0]         w_last_pass;
    logic [3:0]         w_idx;
    logic [4:0]         w_sh;
    logic [31:0]        w_ws;
    logic [31:0]        w_as;
    logic [16:0]        w_we;
    logic [16:0]        w_ae;
    logic [67:0]        w_mult_w;
    logic [67:0]        w_mult_a;
    logic [ACC_W-1:0]   w_sum;

    always_comb begin
        case (r_prec)
            2'b10:   w_last_pass = 2'd1;
            2'b11:   w_last_pass = 2'd3;
            default: w_last_pass = 2'd0;
        endcase
    end

    // Lane i of pass p carries element 4p+i; element k sits at bits [k*b +: b].
    always_comb begin
        w_mult_w = '0;
        w_mult_a = '0;
        w_idx    = '0;
        w_sh     = '0;
        w_ws     = '0;
        w_as     = '0;
        w_we     = '0;
        w_ae     = '0;
        if (r_state == S_ISSUE) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (!(r_prec == 2'b00 && i >= 2)) begin
                    w_idx = {r_pass, 2'(i)};
                    case (r_prec)
                        2'b00:   w_sh = {w_idx[0], 4'b0};
                        2'b01:   w_sh = {w_idx[1:0], 3'b0};
                        2'b10:   w_sh = {w_idx[2:0], 2'b0};
                        default: w_sh = {w_idx, 1'b0};
                    endcase
                    w_ws = r_w >> w_sh;
                    w_as = r_a >> w_sh;
                    case (r_prec)
                        2'b00: begin
                            w_we = {w_ws[15], w_ws[15:0]};
                            w_ae = {r_asg & w_as[15], w_as[15:0]};
                        end
                        2'b01: begin
                            w_we = {{9{w_ws[7]}}, w_ws[7:0]};
                            w_ae = {{9{r_asg & w_as[7]}}, w_as[7:0]};
                        end
                        2'b10: begin
                            w_we = {{13{w_ws[3]}}, w_ws[3:0]};
                            w_ae = {{13{r_asg & w_as[3]}}, w_as[3:0]};
                        end
                        default: begin
                            w_we = {{15{w_ws[1]}}, w_ws[1:0]};
                            w_ae = {{15{r_asg & w_as[1]}}, w_as[1:0]};
                        end
                    endcase
                    w_mult_w[17*i +: 17] = w_we;
                    w_mult_a[17*i +: 17] = w_ae;
                end
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_sum = w_sum + ACC_W'(signed'(r_prod[34*i +: 34]));
        end
    end

    // Products land in r_prod one edge after issue, so the add trails the issue by one pass.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_w     <= '0;
            r_a     <= '0;
            r_prec  <= '0;
            r_asg   <= 1'b0;
            r_pass  <= '0;
            r_prod  <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_w     <= weights_i;
                        r_a     <= acts_i;
                        r_prec  <= prec_i;
                        r_asg   <= act_signed_i;
                        r_pass  <= '0;
                        if (acc_clr_i) r_acc <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_prod <= mult_prods_i;
                    r_pass <= r_pass + 2'd1;
                    if (r_pass != 2'd0) r_acc <= r_acc + w_sum;
                    if (r_pass == w_last_pass) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_acc   <= r_acc + w_sum;
                    r_state <= S_DONE;
                end
                default: begin
                    if (res_ready_i) r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = (r_state == S_IDLE);
    assign res_valid_o    = (r_state == S_DONE);
    assign busy_o         = (r_state != S_IDLE);
    assign res_o          = r_acc;
    assign mult_weights_o = w_mult_w;
    assign mult_acts_o    = w_mult_a;
    assign mult_normal_o  = (r_state == S_ISSUE) && (r_prec == 2'b00);

endmodule

// File: tb/tb_mpnn_mac_sequencer.sv
// Directed bench for mpnn_mac_sequencer with a behavioural 4-lane multiplier;
// a second instance with an 8-bit accumulator exercises wrap-around.
module tb_mpnn_mac_sequencer;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [31:0]  weights_i;
    logic [31:0]  acts_i;
    logic [1:0]   prec_i;
    logic         act_signed_i;
    logic         acc_clr_i;
    logic         res_valid_o;
    logic         res_ready_i;
    logic [31:0]  res_o;
    logic         busy_o;
    logic [67:0]  mult_weights_o;
    logic [67:0]  mult_acts_o;
    logic         mult_normal_o;
    logic [135:0] w_prods;

    logic         req_ready8;
    logic         res_valid8;
    logic [7:0]   res8;
    logic         busy8;
    logic [67:0]  mult_w8;
    logic [67:0]  mult_a8;
    logic         normal8;

    int tests = 0;
    int fails = 0;
    logic sync_bad = 1'b0;

    always #5 clk_i = ~clk_i;

    mpnn_mac_sequencer #(.ACC_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .weights_i(weights_i), .acts_i(acts_i), .prec_i(prec_i), .act_signed_i(act_signed_i),
        .acc_clr_i(acc_clr_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_o(res_o), .busy_o(busy_o), .mult_weights_o(mult_weights_o),
        .mult_acts_o(mult_acts_o), .mult_normal_o(mult_normal_o), .mult_prods_i(w_prods)
    );

    mpnn_mac_sequencer #(.ACC_W(8)) dut8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready8),
        .weights_i(weights_i), .acts_i(acts_i), .prec_i(prec_i), .act_signed_i(act_signed_i),
        .acc_clr_i(acc_clr_i), .res_valid_o(res_valid8), .res_ready_i(res_ready_i),
        .res_o(res8), .busy_o(busy8), .mult_weights_o(mult_w8),
        .mult_acts_o(mult_a8), .mult_normal_o(normal8), .mult_prods_i(w_prods)
    );

    always_comb begin
        w_prods = '0;
        for (int j = 0; j < 4; j++) begin
            w_prods[34*j +: 34] = 34'(signed'(mult_weights_o[17*j +: 17]))
                                * 34'(signed'(mult_acts_o[17*j +: 17]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_job(input logic [31:0] w, input logic [31:0] a, input logic [1:0] p,
                           input logic sg, input logic clr,
                           output logic [31:0] res, output logic [7:0] r8, output int lat,
                           output int norm_cyc, output int issue_cyc,
                           output logic [67:0] first_w);
        int guard;
        guard = 0;
        while (!req_ready_o && guard < 20) begin
            tick;
            guard++;
        end
        weights_i = w; acts_i = a; prec_i = p; act_signed_i = sg; acc_clr_i = clr;
        req_valid_i = 1'b1;
        tick;
        req_valid_i = 1'b0;
        lat = 0; norm_cyc = 0; issue_cyc = 0;
        first_w = mult_weights_o;
        while (!res_valid_o && lat < 20) begin
            if (mult_weights_o != '0) issue_cyc++;
            if (mult_normal_o) norm_cyc++;
            if ({req_ready8, res_valid8, busy8, normal8, mult_w8, mult_a8} !==
                {req_ready_o, res_valid_o, busy_o, mult_normal_o, mult_weights_o, mult_acts_o})
                sync_bad = 1'b1;
            tick;
            lat++;
        end
        res = res_o;
        r8  = res8;
        res_ready_i = 1'b1;
        tick;
        res_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        tick;
        tick;
        rst_ni = 1'b1;
        tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        tests++; if (res_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", res_valid_o); end
        tests++; if (res_o !== 32'd0) begin fails++; $display("FAIL reset_acc: got %h want 0", res_o); end
        tests++; if ({mult_weights_o, mult_acts_o, mult_normal_o} !== '0) begin fails++; $display("FAIL reset_mult: got %h/%h/%b want 0", mult_weights_o, mult_acts_o, mult_normal_o); end
    endtask

    task automatic test_8b;
        logic [31:0] r; logic [7:0] r8; int lat, nc, ic; logic [67:0] fw;
        run_job(32'hFF020301, 32'h04030201, 2'b01, 1'b0, 1'b1, r, r8, lat, nc, ic, fw);
        tests++; if (r !== 32'd9) begin fails++; $display("FAIL 8b_res: got %0d want 9", $signed(r)); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL 8b_latency: got %0d want 2", lat); end
        tests++; if (nc !== 0) begin fails++; $display("FAIL 8b_normal: got %0d cycles want 0", nc); end
        tests++; if (ic !== 1) begin fails++; $display("FAIL 8b_issue_cycles: got %0d want 1", ic); end
        tests++; if (fw !== {17'h1FFFF, 17'h00002, 17'h00003, 17'h00001}) begin fails++; $display("FAIL 8b_lanes: got %h want lanes -1,2,3,1", fw); end
    endtask

    task automatic test_2b;
        logic [31:0] r; logic [7:0] r8; int lat, nc, ic; logic [67:0] fw;
        run_job(32'h55555555, 32'hFFFFFFFF, 2'b11, 1'b0, 1'b1, r, r8, lat, nc, ic, fw);
        tests++; if (r !== 32'd48) begin fails++; $display("FAIL 2b_unsigned: got %0d want 48", $signed(r)); end
        tests++; if (lat !== 5) begin fails++; $display("FAIL 2b_latency: got %0d want 5", lat); end
        tests++; if (ic !== 4) begin fails++; $display("FAIL 2b_issue_cycles: got %0d want 4", ic); end
        run_job(32'h55555555, 32'hFFFFFFFF, 2'b11, 1'b1, 1'b1, r, r8, lat, nc, ic, fw);
        tests++; if (r !== 32'hFFFFFFF0) begin fails++; $display("FAIL 2b_signed: got %0d want -16", $signed(r)); end
        run_job(32'h00000001, 32'h00000009, 2'b10, 1'b0, 1'b1, r, r8, lat, nc, ic, fw);
        tests++; if (r !== 32'd9 || lat !== 3) begin fails++; $display("FAIL 4b_job: got %0d lat %0d want 9 lat 3", $signed(r), lat); end
    endtask

    task automatic test_16b;
        logic [31:0] r; logic [7:0] r8; int lat, nc, ic; logic [67:0] fw;
        run_job(32'h80000002, 32'h00030004, 2'b00, 1'b1, 1'b1, r, r8, lat, nc, ic, fw);
        tests++; if (r !== 32'hFFFE8008) begin fails++; $display("FAIL 16b_res: got %0d want -98296", $signed(r)); end
        tests++; if (nc !== 1) begin fails++; $display("FAIL 16b_normal: got %0d cycles want 1", nc); end
        tests++; if (fw !== {34'd0, 17'h18000, 17'h00002}) begin fails++; $display("FAIL 16b_lanes: got %h want %h", fw, {34'd0, 17'h18000, 17'h00002}); end
        tests++; if (mult_normal_o !== 1'b0) begin fails++; $display("FAIL 16b_normal_idle: got %b want 0", mult_normal_o); end
    endtask

    task automatic test_accumulate;
        logic [31:0] r; logic [7:0] r8; int lat, nc, ic; logic [67:0] fw;
        run_job(32'hFF020301, 32'h04030201, 2'b01, 1'b0, 1'b1, r, r8, lat, nc, ic, fw);
        tests++; if (r !== 32'd9 || r8 !== 8'd9) begin fails++; $display("FAIL acc_first: got %0d/%0d want 9/9", r, r8); end
        run_job(32'hFF020301, 32'h04030201, 2'b01, 1'b0, 1'b0, r, r8, lat, nc, ic, fw);
        tests++; if (r !== 32'd18 || r8 !== 8'd18) begin fails++; $display("FAIL acc_second: got %0d/%0d want 18/18", r, r8); end
        run_job(32'h00002020, 32'h00000202, 2'b01, 1'b0, 1'b1, r, r8, lat, nc, ic, fw);
        tests++; if (r !== 32'd128) begin fails++; $display("FAIL acc_wide: got %0d want 128", r); end
        tests++; if (r8 !== 8'h80) begin fails++; $display("FAIL acc_wrap8: got %h want 80", r8); end
        tests++; if (sync_bad !== 1'b0) begin fails++; $display("FAIL acc8_lockstep: got %b want 0", sync_bad); end
    endtask

    task automatic test_backpressure;
        weights_i = 32'hFF020301; acts_i = 32'h04030201; prec_i = 2'b01;
        act_signed_i = 1'b0; acc_clr_i = 1'b1; req_valid_i = 1'b1;
        tick;
        acc_clr_i = 1'b0;
        tick;
        tick;
        tests++; if (res_valid_o !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b want 1", res_valid_o); end
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (res_o !== 32'd9 || req_ready_o !== 1'b0 || res_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold%0d: got res %0d ready %b valid %b want 9 0 1", c, res_o, req_ready_o, res_valid_o);
            end
            tick;
        end
        res_ready_i = 1'b1;
        tick;
        res_ready_i = 1'b0;
        tests++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1) begin fails++; $display("FAIL bp_idle: got busy %b ready %b want 0 1", busy_o, req_ready_o); end
        tick;
        req_valid_i = 1'b0;
        tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL bp_accept: got busy %b want 1", busy_o); end
        tick;
        tick;
        tests++; if (res_valid_o !== 1'b1 || res_o !== 32'd18) begin fails++; $display("FAIL bp_second: got valid %b res %0d want 1 18", res_valid_o, res_o); end
        res_ready_i = 1'b1;
        tick;
        res_ready_i = 1'b0;
    endtask

    task automatic test_reset_midjob;
        logic [31:0] r; logic [7:0] r8; int lat, nc, ic; logic [67:0] fw;
        weights_i = 32'h55555555; acts_i = 32'hFFFFFFFF; prec_i = 2'b11;
        act_signed_i = 1'b0; acc_clr_i = 1'b0; req_valid_i = 1'b1;
        tick;
        req_valid_i = 1'b0;
        tick;
        tick;
        rst_ni = 1'b0;
        tick;
        rst_ni = 1'b1;
        tests++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1) begin fails++; $display("FAIL rst_mid_state: got busy %b ready %b want 0 1", busy_o, req_ready_o); end
        tests++; if (res_o !== 32'd0) begin fails++; $display("FAIL rst_mid_acc: got %0d want 0", res_o); end
        tests++; if ({mult_weights_o, mult_acts_o} !== '0) begin fails++; $display("FAIL rst_mid_mult: got %h/%h want 0", mult_weights_o, mult_acts_o); end
        run_job(32'h55555555, 32'hFFFFFFFF, 2'b11, 1'b0, 1'b0, r, r8, lat, nc, ic, fw);
        tests++; if (r !== 32'd48) begin fails++; $display("FAIL rst_mid_next: got %0d want 48", r); end
    endtask

    initial begin
        rst_ni = 1'b0; req_valid_i = 1'b0; weights_i = '0; acts_i = '0; prec_i = '0;
        act_signed_i = 1'b0; acc_clr_i = 1'b0; res_ready_i = 1'b0;
        test_reset;
        test_8b;
        test_2b;
        test_16b;
        test_accumulate;
        test_backpressure;
        test_reset_midjob;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
